// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared constants, request struct and overflow helper for the
// add_arbiter slice.
//   REQ_ID_0/REQ_ID_1 : requester IDs reported on res_id and held in last_grant
//   SAT_POS/SAT_NEG   : clamp values used when ADD_ARB_SAT_EN is defined
//   add_op_t          : one requester's operation (operands + subtract flag)
//   ovf_of()          : signed overflow from the adder-input and sum sign bits
package add_arb_pkg;

  localparam int          ADD_W    = 32;
  localparam logic        REQ_ID_0 = 1'b0;
  localparam logic        REQ_ID_1 = 1'b1;
  localparam logic [31:0] SAT_POS  = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG  = 32'h8000_0000;

  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic             sub;
  } add_op_t;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  // Overflow only when both adder inputs share a sign and the sum's differs.
  // b31 is the sign of the adder's B input, i.e. after the subtract inversion.
  function automatic logic ovf_of(input logic a31, input logic b31, input logic s31);
    return (!a31 & !b31 & s31) | (a31 & b31 & !s31);
  endfunction

endpackage

// File: rtl/CLA_32.sv
// CLA_32: 32-bit carry-lookahead adder built from eight 4-bit groups.
// Group generate/propagate terms form the inter-group carry chain; each group
// then resolves its internal carries from its own carry-in.
//   a, b : operands     cin  : carry in
//   sum  : a + b + cin  cout : carry out   ovf : signed overflow of a + b + cin
module CLA_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  logic [31:0] g;
  logic [31:0] p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin : cla
    logic gc;
    logic bc;
    logic gg;
    logic pg;
    sum = '0;
    gc  = cin;
    for (int k = 0; k < 8; k++) begin
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg = &p[4*k +: 4];
      bc = gc;
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ bc;
        bc         = g[4*k+j] | (p[4*k+j] & bc);
      end
      gc = gg | (pg & gc);
    end
    cout = gc;
  end

  assign ovf = (a[31] == b[31]) & (sum[31] != a[31]);

endmodule

// File: rtl/add_rr_pick.sv
// add_rr_pick: combinational two-way round-robin grant.
//   valid0/valid1 : requester valids
//   last_grant    : requester granted most recently (loses a tie)
//   grant0/grant1 : one-hot-or-zero grant
module add_rr_pick
  import add_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  // A lone requester always wins; on a tie the one not granted last wins.
  assign grant0 = valid0 & (!valid1 | (last_grant == REQ_ID_1));
  assign grant1 = valid1 & (!valid0 | (last_grant == REQ_ID_0));

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: shares a single CLA_32 between two add/subtract requesters with
// round-robin arbitration and a one-entry valid/ready result register.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   reqN_valid/ready        : requester handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_sub: operands; sub=1 gives a-b
//   res_valid/res_ready     : result handshake
//   res_data, res_ovf, res_id : registered result, signed overflow, issuer
// Optional: define ADD_ARB_SAT_EN to clamp res_data on signed overflow.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_id
);

  res_state_e       state;
  logic             last_grant;
  logic             slot_free;
  logic             grant0, grant1;
  logic             acc0, acc1, acc;
  add_op_t          op_sel;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] next_data;
  logic             ovf;
  logic             cla_unused_cout;
  logic             cla_unused_ovf;

  assign res_valid = (state == RES_FULL);
  // The register can take a new result if empty or being drained this cycle.
  assign slot_free = (state == RES_EMPTY) | res_ready;

  add_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // Readies drop during reset so no requester sees a handshake that the
  // register will ignore.
  assign req0_ready = grant0 & slot_free & ~reset;
  assign req1_ready = grant1 & slot_free & ~reset;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign acc        = acc0 | acc1;

  always_comb begin
    op_sel = '{a: req0_a, b: req0_b, sub: req0_sub};
    if (acc1) op_sel = '{a: req1_a, b: req1_b, sub: req1_sub};
  end

  // Subtract as a + ~b + 1.
  assign add_b = op_sel.sub ? ~op_sel.b : op_sel.b;

  CLA_32 u_cla (
    .a    (op_sel.a),
    .b    (add_b),
    .cin  (op_sel.sub),
    .sum  (sum),
    .cout (cla_unused_cout),
    .ovf  (cla_unused_ovf)
  );

  // Overflow is taken on the post-inversion operands so subtract is covered.
  assign ovf = ovf_of(op_sel.a[WIDTH-1], add_b[WIDTH-1], sum[WIDTH-1]);

`ifdef ADD_ARB_SAT_EN
  // On overflow the true result has the sign of A, so clamp toward it.
  assign next_data = ovf ? (op_sel.a[WIDTH-1] ? SAT_NEG : SAT_POS) : sum;
`else
  assign next_data = sum;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RES_EMPTY;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      res_id     <= REQ_ID_0;
      last_grant <= REQ_ID_1;
    end else if (acc) begin
      state      <= RES_FULL;
      res_data   <= next_data;
      res_ovf    <= ovf;
      res_id     <= acc1 ? REQ_ID_1 : REQ_ID_0;
      last_grant <= acc1 ? REQ_ID_1 : REQ_ID_0;
    end else if ((state == RES_FULL) && res_ready) begin
      state <= RES_EMPTY;
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_ovf, res_id;
  logic [31:0] res_data;

  always #5 clock = ~clock;

  add_arbiter #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .res_id     (res_id)
  );

  int tests = 0;
  int fails = 0;

  // reference state: what the result port should show, and who won last
  logic        m_valid, m_ovf, m_id, m_last, m_acc0, m_acc1;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact arithmetic in 64 bits; overflow means the true value leaves int32.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, output logic [31:0] d, output logic o);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    o  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    d  = r[31:0];
`ifdef ADD_ARB_SAT_EN
    if (o) d = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
  endfunction

  // Called at a negedge with inputs driven: checks readies, advances one edge,
  // then checks the result port.
  task automatic tick();
    logic slot, w0, w1, e0, e1, o;
    logic [31:0] d;
    #1;
    slot = !m_valid || res_ready;
    w0 = req0_valid && (!req1_valid || m_last);
    w1 = req1_valid && (!req0_valid || !m_last);
    e0 = !reset && w0 && slot;
    e1 = !reset && w1 && slot;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    m_acc0 = e0;
    m_acc1 = e1;
    if (reset) begin
      m_valid = 0; m_data = 0; m_ovf = 0; m_id = 0; m_last = 1;
    end else if (e0 || e1) begin
      if (e1) ref_add(req1_a, req1_b, req1_sub, d, o);
      else    ref_add(req0_a, req0_b, req0_sub, d, o);
      m_valid = 1; m_data = d; m_ovf = o; m_id = e1; m_last = e1;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    @(posedge clock);
    @(negedge clock);
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
    chk("res_data",  res_data, m_data);
    chk("res_ovf",   {31'd0, res_ovf}, {31'd0, m_ovf});
    chk("res_id",    {31'd0, res_id}, {31'd0, m_id});
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom % 6)
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic prev_id;
    m_valid = 0; m_data = 0; m_ovf = 0; m_id = 0; m_last = 1;
    m_acc0 = 0; m_acc1 = 0;
    reset = 1; res_ready = 0;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    tick(); tick();
    chk("reset_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_data",  res_data, 32'd0);

    reset = 0; res_ready = 1;
    set0(1, 32'd5, 32'd7, 0); tick(); set0(0, 0, 0, 0);
    chk("add_5_7", res_data, 32'd12);
    chk("add_5_7_id", {31'd0, res_id}, 32'd0);

    set1(1, 32'h7FFF_FFFF, 32'd1, 0); tick(); set1(0, 0, 0, 0);
    chk("pos_ovf", {31'd0, res_ovf}, 32'd1);
`ifdef ADD_ARB_SAT_EN
    chk("pos_ovf_data", res_data, 32'h7FFF_FFFF);
`else
    chk("pos_ovf_data", res_data, 32'h8000_0000);
`endif

    set0(1, 32'h8000_0000, 32'd1, 1); tick();
    chk("neg_ovf", {31'd0, res_ovf}, 32'd1);
`ifdef ADD_ARB_SAT_EN
    chk("neg_ovf_data", res_data, 32'h8000_0000);
`else
    chk("neg_ovf_data", res_data, 32'h7FFF_FFFF);
`endif
    set0(1, 32'd3, 32'd10, 1); tick();
    chk("sub_3_10", res_data, 32'hFFFF_FFF9);
    chk("sub_3_10_ovf", {31'd0, res_ovf}, 32'd0);

    // give req1 one turn so the tie run starts with req0
    set0(0, 0, 0, 0); set1(1, 32'd1, 32'd1, 0); tick();
    set0(1, 32'd100, 32'd1, 0); set1(1, 32'd200, 32'd2, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_id", {31'd0, res_id}, i[0] ? 32'd1 : 32'd0);
      chk("tie_valid", {31'd0, res_valid}, 32'd1);
    end

    // stall while FULL: nothing accepted, data frozen
    res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", res_data, 32'd198);
    end
    res_ready = 1; tick();
    chk("stall_release", res_data, 32'd101);

    // reset while FULL and both valid
    res_ready = 0; tick();
    reset = 1; tick();
    chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
    reset = 0; res_ready = 1; tick();
    chk("rst_tie_id", {31'd0, res_id}, 32'd0);

    // randomized traffic; a waiting requester keeps its operation stable
    for (int i = 0; i < 400; i++) begin
      prev_id = 0;
      if (!(req0_valid && !m_acc0) || reset)
        set0(($urandom % 10) < 7, pick_opnd(), pick_opnd(), $urandom % 2);
      if (!(req1_valid && !m_acc1) || reset)
        set1(($urandom % 10) < 7, pick_opnd(), pick_opnd(), $urandom % 2);
      res_ready = ($urandom % 4) != 0;
      reset = ($urandom % 60) == 0;
      tick();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
